// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared mode constants, state type and lowest-set-bit helper
package prio_enc_pkg;
  localparam int MODE_SINGLE = 0;
  localparam int MODE_DRAIN = 1;
  typedef enum logic {IDLE, BUSY} enc_state_t;
  function automatic int lsb_idx(logic [63:0] vec, int n);
    int r = 0;
    for (int i = n - 1; i >= 0; i--) r = vec[i] ? i : r;
    return r;
  endfunction
endpackage

// File: rtl/lsb_finder.sv
// lsb_finder: lowest set bit of a vector as binary index, presence flag and one-hot mask
module lsb_finder
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found,
  output logic [N-1:0] onehot
);
  assign idx = W'(lsb_idx(64'(vec), N));
  assign found = |vec;
  assign onehot = vec & (~vec + N'(1));
endmodule

// File: rtl/prio_encoder_stream.sv
// prio_encoder_stream: registered valid/ready priority encoder with optional per-bit drain
module prio_encoder_stream
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int MODE = MODE_SINGLE,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_zero,
  output logic         out_multi,
  output logic         out_last
);
  enc_state_t r_state, w_state;
  logic [N-1:0] r_mask, w_mask, w_req_oh, w_mask_oh, w_req_rest, w_mask_rest;
  logic [W-1:0] r_idx, w_idx, w_req_idx, w_mask_idx;
  logic r_zero, w_zero, r_multi, w_multi, r_last, w_last;
  logic w_req_found, w_mask_found, w_accept, w_consume, w_step;
  lsb_finder #(.N(N)) u_req (.vec(req), .idx(w_req_idx), .found(w_req_found), .onehot(w_req_oh));
  lsb_finder #(.N(N)) u_mask (.vec(r_mask), .idx(w_mask_idx), .found(w_mask_found), .onehot(w_mask_oh));
  assign w_req_rest = req & ~w_req_oh;
  assign w_mask_rest = r_mask & ~w_mask_oh;
  assign out_valid = r_state == BUSY;
  assign in_ready = (r_state == IDLE) || (out_ready && r_last);
  assign w_accept = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;
  assign w_step = w_consume && w_mask_found;
  assign out_idx = r_idx;
  assign out_zero = r_zero;
  assign out_multi = r_multi;
  assign out_last = r_last;
  always_comb begin
    w_state = w_accept ? BUSY : (w_consume && !w_mask_found) ? IDLE : r_state;
    w_idx = w_accept ? w_req_idx : w_step ? w_mask_idx : r_idx;
    w_zero = w_accept ? !w_req_found : w_step ? 1'b0 : r_zero;
    w_multi = w_accept ? |w_req_rest : r_multi;
    w_mask = w_accept ? (MODE == MODE_DRAIN ? w_req_rest : '0) : w_step ? w_mask_rest : r_mask;
    w_last = w_accept ? (MODE == MODE_SINGLE || !(|w_req_rest)) : w_step ? !(|w_mask_rest) : r_last;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_mask <= '0;
      r_idx <= '0;
      r_zero <= 1'b0;
      r_multi <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mask <= w_mask;
      r_idx <= w_idx;
      r_zero <= w_zero;
      r_multi <= w_multi;
      r_last <= w_last;
    end
endmodule

// File: tb/tb_prio_encoder_stream.sv
// tb_prio_encoder_stream: beat-queue reference model plus literal checks over three encoder configurations
module tb_prio_encoder_stream;
  localparam int NI = 3;
  typedef struct packed { logic [3:0] idx; logic zero, multi, last; } beat_t;
  typedef struct { bit en, full, v; int idx; bit z, m, l, r; } lit_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [NI-1:0] in_valid, in_ready, out_valid, out_ready, out_zero, out_multi, out_last;
  logic [NI-1:0][15:0] req;
  logic [NI-1:0][3:0] out_idx;
  int nw [NI] = '{8, 8, 13};
  bit drain [NI] = '{1'b0, 1'b1, 1'b1};
  beat_t q [NI][$];
  lit_t lit [NI];
  int n_cmp = 0;
  int n_err = 0;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NN = (g == 2) ? 13 : 8;
    localparam int MM = (g == 0) ? 0 : 1;
    logic [$clog2(NN)-1:0] w_idx;
    prio_encoder_stream #(.N(NN), .MODE(MM)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .req(req[g][NN-1:0]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_idx(w_idx), .out_zero(out_zero[g]), .out_multi(out_multi[g]), .out_last(out_last[g]));
    assign out_idx[g] = 4'(w_idx);
  end
  function automatic void chk(string nm, int i, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, i, act, exp, $time);
    end
  endfunction
  function automatic void push_vec(int i, logic [15:0] v);
    int p, seen;
    p = $countones(v);
    seen = 0;
    if (v == 0) q[i].push_back('{idx: 4'd0, zero: 1'b1, multi: 1'b0, last: 1'b1});
    for (int k = 0; k < 16; k++)
      if (v[k] && (drain[i] || seen == 0)) begin
        seen++;
        q[i].push_back('{idx: 4'(k), zero: 1'b0, multi: p > 1, last: !drain[i] || seen == p});
      end
  endfunction
  always @(negedge clk) begin
    bit ev, er;
    for (int i = 0; i < NI; i++) begin
      ev = q[i].size() > 0;
      er = 1'b1;
      if (ev) er = out_ready[i] && q[i][0].last;
      chk("out_valid", i, out_valid[i], ev);
      chk("in_ready", i, in_ready[i], er);
      if (ev) begin
        chk("out_idx", i, out_idx[i], q[i][0].idx);
        chk("out_zero", i, out_zero[i], q[i][0].zero);
        chk("out_multi", i, out_multi[i], q[i][0].multi);
        chk("out_last", i, out_last[i], q[i][0].last);
      end
      if (lit[i].en) begin
        chk("lit_valid", i, out_valid[i], lit[i].v);
        chk("lit_ready", i, in_ready[i], lit[i].r);
        if (lit[i].full) begin
          chk("lit_idx", i, out_idx[i], lit[i].idx);
          chk("lit_zero", i, out_zero[i], lit[i].z);
          chk("lit_multi", i, out_multi[i], lit[i].m);
          chk("lit_last", i, out_last[i], lit[i].l);
        end
      end
      if (!rst_n) q[i].delete();
      else begin
        if (ev && out_ready[i]) void'(q[i].pop_front());
        if (in_valid[i] && er) push_vec(i, req[i] & 16'((32'd1 << nw[i]) - 32'd1));
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) lit[i].en = 1'b0;
  endtask
  task automatic set_lit(int i, bit full, bit v, int idx, bit z, bit m, bit l, bit r);
    lit[i] = '{en: 1'b1, full: full, v: v, idx: idx, z: z, m: m, l: l, r: r};
  endtask
  task automatic rand_phase(int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid[i] = $urandom_range(0, 3) != 0;
        out_ready[i] = $urandom_range(0, 3) != 0;
        case ($urandom_range(0, 3))
          0: req[i] = '0;
          1: req[i] = 16'(1) << $urandom_range(0, nw[i] - 1);
          default: req[i] = 16'($urandom);
        endcase
      end
      cyc();
    end
  endtask
  initial begin
    in_valid = '0;
    out_ready = '0;
    req = '0;
    for (int i = 0; i < NI; i++) lit[i] = '{en: 1'b0, full: 1'b0, v: 1'b0, idx: 0, z: 1'b0, m: 1'b0, l: 1'b0, r: 1'b0};
    repeat (2) cyc();
    rst_n = 1'b1;
    rand_phase(40);
    rst_n = 1'b0;
    in_valid = '0;
    cyc();
    rst_n = 1'b1;
    out_ready = '1;
    for (int k = 0; k <= 13; k++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid[i] = k < nw[i];
        req[i] = 16'(1) << k;
        if (k == 0) set_lit(i, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        else if (k <= nw[i]) set_lit(i, 1'b1, 1'b1, k - 1, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      cyc();
    end
    in_valid[0] = 1'b1;
    req[0] = 16'h00;
    cyc();
    req[0] = 16'h28;
    set_lit(0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc();
    in_valid[0] = 1'b0;
    set_lit(0, 1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    in_valid[1] = 1'b1;
    req[1] = 16'hA5;
    cyc();
    req[1] = 16'h10;
    set_lit(1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_lit(1, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_lit(1, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_lit(1, 1'b1, 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    in_valid[1] = 1'b0;
    set_lit(1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    in_valid[1] = 1'b1;
    req[1] = 16'h06;
    out_ready[1] = 1'b0;
    cyc();
    req[1] = 16'hFF;
    repeat (3) begin
      set_lit(1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    set_lit(1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_lit(1, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    set_lit(1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    in_valid[1] = 1'b1;
    req[1] = 16'hFF;
    cyc();
    in_valid[1] = 1'b0;
    set_lit(1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b0;
    set_lit(1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    in_valid[1] = 1'b1;
    req[1] = 16'h01;
    set_lit(1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    in_valid[1] = 1'b0;
    set_lit(1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    set_lit(1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    rand_phase(2000);
    in_valid = '0;
    out_ready = '1;
    repeat (40) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
